// File: rtl/band_id_trig_pkg.sv
// Shared constants and entry layout for the band-ID trigger path.
package band_id_trig_pkg;

   localparam int BAND_ID_W = 8;
   localparam logic [BAND_ID_W-1:0] NO_BAND_ID = 8'hFF;
   localparam int TS_WIDTH_DEF = 12;

   // Buffered event as it appears on m_data at the default timestamp width.
   typedef struct packed {
      logic [BAND_ID_W-1:0]    band_id;
      logic [TS_WIDTH_DEF-1:0] ts;
   } entry_t;

endpackage

// File: rtl/band_id_event_buffer_if.sv
// Write/read port bundle between the event-buffer control logic and its FIFO.
interface band_id_event_buffer_if #(
   parameter int DATA_W = 20,
   parameter int CNT_W  = 5
);
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [CNT_W-1:0]  count;
   logic              clear;

   modport master (
      output wr_en, wr_data, rd_en, clear,
      input  full, rd_data, rd_valid, count
   );

   modport slave (
      input  wr_en, wr_data, rd_en, clear,
      output full, rd_data, rd_valid, count
   );
endinterface

// File: rtl/band_id_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_en pops only when an entry is present.
module band_id_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 20
) (
   input logic                   clk,
   input logic                   rst,
   band_id_event_buffer_if.slave fifo
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [AW:0]       count;
   logic              push;
   logic              pop;

   assign pop  = fifo.rd_en && (count != '0);
   // When full, a write is only legal because the head leaves in the same cycle.
   assign push = fifo.wr_en && ((count != FULL_CNT) || pop);

   // NOTE: the storage array has no reset; pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= fifo.wr_data;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || fifo.clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign fifo.full     = (count == FULL_CNT);
   assign fifo.rd_valid = (count != '0);
   assign fifo.rd_data  = fifo.rd_valid ? mem[rd_ptr] : '0;
   assign fifo.count    = count;

endmodule

// File: rtl/band_id_event_buffer.sv
// Timestamps, filters and buffers band-ID events; define BAND_ID_DEDUP_EN to suppress
// repeats of the last accepted band inside DEDUP_WINDOW cycles.
module band_id_event_buffer
   import band_id_trig_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int TS_WIDTH     = 12,
   parameter int DEDUP_WINDOW = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [BAND_ID_W-1:0]          band_id,
   input  logic                          band_valid,
   input  logic                          flush,
   output logic [BAND_ID_W+TS_WIDTH-1:0] m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [15:0]                   drop_cnt
);

   localparam int DATA_W = BAND_ID_W + TS_WIDTH;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   band_id_event_buffer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) fifo_bus ();

   band_id_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .fifo (fifo_bus.slave)
   );

   logic [TS_WIDTH-1:0] ts;
   logic cand, no_match, dup, pop, full_drop, accept, drop;

   // A flush discards the same-cycle candidate silently, so it never reaches the filters.
   assign cand     = band_valid && !flush;
   assign no_match = (band_id == NO_BAND_ID);
   assign pop      = m_valid && m_ready;

`ifdef BAND_ID_DEDUP_EN
   logic [BAND_ID_W-1:0] last_id;
   logic [TS_WIDTH-1:0]  last_ts;
   logic [TS_WIDTH-1:0]  ts_age;
   logic                 last_vld;

   assign ts_age = ts - last_ts;
   assign dup    = last_vld && (band_id == last_id) && (ts_age < TS_WIDTH'(DEDUP_WINDOW));

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         last_vld <= 1'b0;
         last_id  <= '0;
         last_ts  <= '0;
      end else if (accept) begin
         last_vld <= 1'b1;
         last_id  <= band_id;
         last_ts  <= ts;
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign full_drop = cand && !no_match && !dup && fifo_bus.full && !pop;
   assign accept    = cand && !no_match && !dup && !full_drop;
   assign drop      = cand && (no_match || dup || full_drop);

   assign fifo_bus.wr_en   = accept;
   assign fifo_bus.wr_data = {band_id, ts};
   assign fifo_bus.rd_en   = m_ready;
   assign fifo_bus.clear   = flush;

   assign m_data     = fifo_bus.rd_data;
   assign m_valid    = fifo_bus.rd_valid;
   assign fifo_count = fifo_bus.count;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts       <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         ts <= ts + 1'b1;
         if (full_drop) overflow <= 1'b1;
         if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_band_id_event_buffer.sv
// Randomized and directed bench for band_id_event_buffer against a queue-based reference model.
module tb_band_id_event_buffer;
   import band_id_trig_pkg::*;

   localparam int DEPTH  = 16;
   localparam int TSW    = 12;
   localparam int WIN    = 4;
   localparam int TS_MOD = 1 << TSW;
   localparam int DW     = BAND_ID_W + TSW;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst = 1'b1;
   logic                 band_valid = 1'b0;
   logic                 flush = 1'b0;
   logic                 m_ready = 1'b0;
   logic [BAND_ID_W-1:0] band_id = '0;
   logic                 overflow;
   logic [15:0]          drop_cnt;

   band_id_event_buffer_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

   band_id_event_buffer #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW), .DEDUP_WINDOW(WIN)) dut (
      .clk        (clk),
      .rst        (rst),
      .band_id    (band_id),
      .band_valid (band_valid),
      .flush      (flush),
      .m_data     (bus.rd_data),
      .m_valid    (bus.rd_valid),
      .m_ready    (m_ready),
      .fifo_count (bus.count),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
   );

   // Reference model: an ordered list of events plus the filter rules in plain arithmetic.
   entry_t               q[$];
   int                   ts_m;
   bit                   ovf_m;
   int                   drops_m;
   bit                   last_vld_m;
   logic [BAND_ID_W-1:0] last_id_m;
   int                   last_ts_m;

   int    n_checks = 0;
   int    n_pass   = 0;
   string phase    = "init";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s.%s: got %0h, expected %0h", phase, tag, got, exp);
   endtask

   task automatic model_step();
      bit popped, took, dropped;
      popped = 0; took = 0; dropped = 0;
      if (rst) begin
         q.delete();
         ts_m = 0; ovf_m = 0; drops_m = 0; last_vld_m = 0;
      end else if (flush) begin
         q.delete();
         last_vld_m = 0;
         ts_m = (ts_m + 1) % TS_MOD;
      end else begin
         popped = (q.size() != 0) && m_ready;
         if (band_valid) begin
            if (band_id == NO_BAND_ID) dropped = 1;
`ifdef BAND_ID_DEDUP_EN
            else if (last_vld_m && band_id == last_id_m &&
                     ((ts_m - last_ts_m + TS_MOD) % TS_MOD) < WIN) dropped = 1;
`endif
            else if (q.size() == DEPTH && !popped) begin
               dropped = 1;
               ovf_m = 1;
            end else took = 1;
         end
         if (popped) void'(q.pop_front());
         if (took) begin
            q.push_back('{band_id: band_id, ts: TSW'(ts_m)});
            last_vld_m = 1; last_id_m = band_id; last_ts_m = ts_m;
         end
         if (dropped && drops_m < 65535) drops_m++;
         ts_m = (ts_m + 1) % TS_MOD;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("m_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
      check("m_data", 32'(bus.rd_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      check("fifo_count", 32'(bus.count), 32'(q.size()));
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("drop_cnt", 32'(drop_cnt), 32'(drops_m));
   endtask

   task automatic apply(input bit v, input logic [7:0] id, input bit rdy, input bit fl);
      band_valid = v; band_id = id; m_ready = rdy; flush = fl;
      cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(0, 8'h00, 0, 0);
      apply(0, 8'h00, 0, 0);
      rst = 1'b0;
   endtask

   // Idles until the next consumed cycle carries timestamp t; bounded by one full wrap.
   task automatic goto_ts(input int t, input bit rdy);
      for (int i = 0; i < TS_MOD && ts_m != t; i++) apply(0, 8'h00, rdy, 0);
   endtask

   initial begin
      phase = "reset";
      do_reset();
      check("rst_m_valid", 32'(bus.rd_valid), 32'd0);
      check("rst_m_data", 32'(bus.rd_data), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);

      phase = "first_event";
      goto_ts(5, 1);
      apply(1, 8'h12, 1, 0);
      check("head", 32'(bus.rd_data), 32'({8'h12, 12'd5}));
      check("valid", 32'(bus.rd_valid), 32'd1);
      apply(0, 8'h00, 1, 0);
      check("drained", 32'(bus.rd_valid), 32'd0);

      phase = "no_match";
      do_reset();
      apply(1, 8'hFF, 1, 0);
      check("drop_cnt", 32'(drop_cnt), 32'd1);
      check("overflow", 32'(overflow), 32'd0);
      check("count", 32'(bus.count), 32'd0);

      phase = "dedup";
      do_reset();
      goto_ts(100, 0); apply(1, 8'h20, 0, 0);
      goto_ts(103, 0); apply(1, 8'h20, 0, 0);
`ifdef BAND_ID_DEDUP_EN
      check("count_103", 32'(bus.count), 32'd1);
`else
      check("count_103", 32'(bus.count), 32'd2);
`endif
      goto_ts(104, 0); apply(1, 8'h20, 0, 0);
`ifdef BAND_ID_DEDUP_EN
      check("count_104", 32'(bus.count), 32'd2);
      check("drops", 32'(drop_cnt), 32'd1);
`else
      check("count_104", 32'(bus.count), 32'd3);
      check("drops", 32'(drop_cnt), 32'd0);
`endif

      phase = "full";
      do_reset();
      for (int i = 1; i <= 17; i++) apply(1, 8'(i), 0, 0);
      check("count", 32'(bus.count), 32'd16);
      check("overflow", 32'(overflow), 32'd1);
      check("drop_cnt", 32'(drop_cnt), 32'd1);
      apply(1, 8'h40, 1, 0);
      check("count_swap", 32'(bus.count), 32'd16);
      check("head_swap", 32'(bus.rd_data), 32'({8'h02, 12'd1}));
      check("drop_swap", 32'(drop_cnt), 32'd1);

      phase = "wrap";
      do_reset();
      goto_ts(4094, 1); apply(1, 8'h33, 1, 0);
      goto_ts(1, 1);    apply(1, 8'h33, 1, 0);
`ifdef BAND_ID_DEDUP_EN
      check("drop_wrap", 32'(drop_cnt), 32'd1);
`else
      check("drop_wrap", 32'(drop_cnt), 32'd0);
`endif

      phase = "flush";
      do_reset();
      for (int i = 0; i < 5; i++) apply(1, 8'(8'h50 + i), 0, 0);
      check("count_pre", 32'(bus.count), 32'd5);
      apply(1, 8'h60, 0, 1);
      check("count", 32'(bus.count), 32'd0);
      check("valid", 32'(bus.rd_valid), 32'd0);
      check("drop_cnt", 32'(drop_cnt), 32'd0);
      apply(1, 8'h54, 0, 0);
      check("after_flush", 32'(bus.count), 32'd1);

      phase = "mid_reset";
      for (int i = 0; i < 3; i++) apply(1, 8'(8'h70 + i), 0, 0);
      rst = 1'b1;
      apply(1, 8'h7A, 1, 1);
      rst = 1'b0;
      check("count", 32'(bus.count), 32'd0);

      phase = "random";
      do_reset();
      for (int blk = 0; blk < 12; blk++) begin
         int rdy_pct;
         rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
         for (int i = 0; i < 200; i++) begin
            logic [7:0] id;
            id  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(1, 5));
            rst = ($urandom_range(0, 499) == 0);
            apply($urandom_range(0, 3) != 0, id, $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 99) < 2);
         end
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/band_id_event_buffer.md
BAND_ID_EVENT_BUFFER -- requirements
Module: band_id_event_buffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, entry count (power of two, 4..256).
REQ-002 SHALL have parameter TS_WIDTH, default 12, timestamp width in bits.
REQ-003 SHALL have parameter DEDUP_WINDOW, default 4, duplicate-suppression window in cycles (1..2^TS_WIDTH-1).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port band_id  input  8  band ID from the band-ID lookup stage.
REQ-007 SHALL have port band_valid  input  1  band_id is valid this cycle.
REQ-008 SHALL have port flush  input  1  synchronous clear of buffered entries.
REQ-009 SHALL have port m_data  output  8+TS_WIDTH  {band_id, timestamp} of the head entry.
REQ-010 SHALL have port m_valid  output  1  head entry available.
REQ-011 SHALL have port m_ready  input  1  consumer accepts the head entry.
REQ-012 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky; set on any full-drop.
REQ-014 SHALL have port drop_cnt  output  16  saturating count of all dropped inputs.

Function
REQ-015 SHALL run a free-running TS_WIDTH-bit timestamp counter, +1 per cycle, wrapping 2^TS_WIDTH-1 -> 0.
REQ-016 SHALL, on band_valid=1, form candidate {band_id, current timestamp}.
REQ-017 SHALL drop a candidate whose band_id is 8'hFF (no-match code), incrementing drop_cnt.
REQ-018 SHALL drop a candidate whose band_id equals the last accepted band_id and whose (ts - last_ts) mod 2^TS_WIDTH < DEDUP_WINDOW, while a last accepted entry exists (dedup, see REQ-029).
REQ-019 SHALL push accepted candidates; last_id/last_ts update only on push.
REQ-020 SHALL, when full and m_ready&&m_valid is low that cycle, drop the candidate, set overflow, increment drop_cnt.
REQ-021 SHALL accept a push when full if a pop occurs the same cycle; fifo_count unchanged.
REQ-022 SHALL be first-word-fall-through: candidate pushed into an empty FIFO at cycle N gives m_valid=1 with its m_data at cycle N+1.
REQ-023 SHALL pop on m_valid&&m_ready; m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-024 SHALL, on flush=1, empty the FIFO and clear last-entry tracking next cycle, discard any same-cycle candidate without counting it; timestamp, overflow, drop_cnt unaffected.
REQ-025 SHALL saturate drop_cnt at 16'hFFFF.

Reset
REQ-026 SHALL on rst=1 set timestamp=0, fifo_count=0, m_valid=0, m_data=0, overflow=0, drop_cnt=0, last-entry tracking invalid.
REQ-027 SHALL let rst override flush, band_valid and m_ready in the same cycle; reset mid-stream discards all entries.
REQ-028 SHALL accept no candidate during a rst=1 cycle; first accepted candidate carries timestamp 0 if presented the cycle after reset release.

Configuration
REQ-029 SHALL, with macro BAND_ID_DEDUP_EN defined, implement REQ-018; without it, omit last_id/last_ts logic, and every non-8'hFF candidate is a push candidate.

Structure
REQ-030 SHALL place NO_BAND_ID (8'hFF), BAND_ID_W (8), and the entry struct typedef {band_id, ts} in shared package band_id_trig_pkg.
REQ-031 SHALL implement storage as one sub-module band_id_fifo (sync FWFT FIFO, push/pop/full/empty/count); filtering, timestamp and counters stay in the top.

Verification
REQ-032 SHALL cover: reset release, band_valid=1 band_id=8'h12 at ts=5, m_ready=1 -> next cycle m_valid=1, m_data={8'h12,12'd5}, then empty.
REQ-033 SHALL cover: band_id=8'hFF with band_valid=1 -> no push, drop_cnt=1, overflow=0.
REQ-034 SHALL cover (dedup on): band 8'h20 at ts=100 and 103 -> one entry; at ts=104 -> second entry; dedup off -> three entries, none dropped.
REQ-035 SHALL cover: m_ready=0, 17 distinct valid candidates -> fifo_count=16, overflow=1, drop_cnt=1; then full plus simultaneous pop and push -> accepted, count stays 16.
REQ-036 SHALL cover: timestamp wrap 4095->0 with same band at ts=4094 and ts=1 -> diff 3 < 4, dropped (dedup on).
REQ-037 SHALL cover: flush with 5 entries and a same-cycle candidate -> fifo_count=0, m_valid=0 next cycle, drop_cnt unchanged.
